// File: rtl/rtc_bus_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_bus_seq_if
//  Description : Command/response and multiplexed RTC bus signals of
//                rtc_bus_seq, grouped for port connection.
//  Revision    : 1.0  initial release
// ============================================================================
interface rtc_bus_seq_if;
    // Command side (from the system controller)
    logic       start;
    logic [2:0] op;
    logic       cfg_format;
    logic       cfg_crono;
    logic [7:0] w_seg, w_min, w_hor, w_dia, w_mes, w_anio, w_cseg, w_cmin, w_chor;
    // Response side
    logic [7:0] r_seg, r_min, r_hor, r_dia, r_mes, r_anio, r_cseg, r_cmin, r_chor;
    logic       busy;
    logic       done;
    // RTC multiplexed address/data bus
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad_n;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [7:0] bus_in;

    // Sequencer view
    modport slave (
        input  start, op, cfg_format, cfg_crono,
        input  w_seg, w_min, w_hor, w_dia, w_mes, w_anio, w_cseg, w_cmin, w_chor,
        output r_seg, r_min, r_hor, r_dia, r_mes, r_anio, r_cseg, r_cmin, r_chor,
        output busy, done,
        output cs_n, rd_n, wr_n, ad_n, bus_out, bus_oe,
        input  bus_in
    );

    // Controller / RTC-side view
    modport master (
        output start, op, cfg_format, cfg_crono,
        output w_seg, w_min, w_hor, w_dia, w_mes, w_anio, w_cseg, w_cmin, w_chor,
        input  r_seg, r_min, r_hor, r_dia, r_mes, r_anio, r_cseg, r_cmin, r_chor,
        input  busy, done,
        input  cs_n, rd_n, wr_n, ad_n, bus_out, bus_oe,
        output bus_in
    );
endinterface
`default_nettype wire

// File: rtl/rtc_bus_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_bus_seq
//  Description : Executes RTC register transactions over an Intel-style
//                multiplexed address/data bus. Each op runs a fixed list of
//                transfers; each transfer is ADDR_A, ADDR_B, DATA_A, DATA_B,
//                GAP, every phase lasting T_PHASE clocks.
//  Revision    : 1.0  initial release
// ============================================================================
module rtc_bus_seq #(
    parameter int         T_PHASE  = 10,
    parameter logic [7:0] CFG_ADDR = 8'h00
) (
    input  wire logic   clock,
    input  wire logic   reset,
    rtc_bus_seq_if.slave bus
);

    localparam int             CW       = $clog2(T_PHASE);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(T_PHASE - 1);

    localparam logic [2:0] OP_CFG    = 3'd1;
    localparam logic [2:0] OP_READ   = 3'd2;
    localparam logic [2:0] OP_TIME   = 3'd3;
    localparam logic [2:0] OP_DATE   = 3'd4;
    localparam logic [2:0] OP_CHRONO = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR_A = 3'd1,
        S_ADDR_B = 3'd2,
        S_DATA_A = 3'd3,
        S_DATA_B = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    typedef struct packed {
        logic       rd;
        logic [7:0] addr;
        logic [7:0] data;
    } xfer_t;

    // Register address of read transfer n (n = 1..9) in the read-all list
    function automatic logic [7:0] read_addr(input logic [3:0] f_idx);
        logic [7:0] a;
        case (f_idx)
            4'd1:    a = 8'h21;
            4'd2:    a = 8'h22;
            4'd3:    a = 8'h23;
            4'd4:    a = 8'h24;
            4'd5:    a = 8'h25;
            4'd6:    a = 8'h26;
            4'd7:    a = 8'h41;
            4'd8:    a = 8'h42;
            4'd9:    a = 8'h43;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    // Transfer descriptor for entry f_idx of the list belonging to f_op
    function automatic xfer_t decode(input logic [2:0]      f_op,
                                     input logic [3:0]      f_idx,
                                     input logic [8:0][7:0] f_wd,
                                     input logic [1:0]      f_cfg);
        xfer_t x;
        x.rd   = 1'b0;
        x.addr = 8'h00;
        x.data = 8'h00;
        case (f_op)
            OP_CFG: begin
                x.addr = CFG_ADDR;
                x.data = {6'b0, f_cfg};
            end
            OP_READ: begin
                if (f_idx == 4'd0) begin
                    x.addr = 8'hF0;
                end else begin
                    x.rd   = 1'b1;
                    x.addr = read_addr(f_idx);
                end
            end
            OP_TIME: begin
                case (f_idx)
                    4'd0:    begin x.addr = 8'h21; x.data = f_wd[0]; end
                    4'd1:    begin x.addr = 8'h22; x.data = f_wd[1]; end
                    4'd2:    begin x.addr = 8'h23; x.data = f_wd[2]; end
                    default: x.addr = 8'hF1;
                endcase
            end
            OP_DATE: begin
                case (f_idx)
                    4'd0:    begin x.addr = 8'h24; x.data = f_wd[3]; end
                    4'd1:    begin x.addr = 8'h25; x.data = f_wd[4]; end
                    4'd2:    begin x.addr = 8'h26; x.data = f_wd[5]; end
                    default: x.addr = 8'hF1;
                endcase
            end
            OP_CHRONO: begin
                case (f_idx)
                    4'd0:    begin x.addr = 8'h41; x.data = f_wd[6]; end
                    4'd1:    begin x.addr = 8'h42; x.data = f_wd[7]; end
                    4'd2:    begin x.addr = 8'h43; x.data = f_wd[8]; end
                    default: x.addr = 8'hF2;
                endcase
            end
            default: ;
        endcase
        return x;
    endfunction

    // Index of the final transfer in the list of f_op
    function automatic logic [3:0] last_idx(input logic [2:0] f_op);
        logic [3:0] n;
        case (f_op)
            OP_CFG:  n = 4'd0;
            OP_READ: n = 4'd9;
            default: n = 4'd3;
        endcase
        return n;
    endfunction

    // FSM and sequencing state
    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [3:0]      idx, idx_nx;
    logic            accept;
    logic            finish;

    // Snapshot of the accepted command
    logic [2:0]      op_q;
    logic [1:0]      cfg_q;
    logic [8:0][7:0] snap;
    logic [8:0][7:0] w_in;
    logic            op_valid;

    // Read-back registers, index 0 = seg ... 8 = chor
    logic [8:0][7:0] r_q;
    logic            capture;
    logic [3:0]      rd_tgt;

    // Registered bus strobes and their next values
    logic            busy_q, done_q;
    logic            cs_n_q, rd_n_q, wr_n_q, ad_n_q, bus_oe_q;
    logic [7:0]      bus_out_q;
    logic            cs_n_nx, rd_n_nx, wr_n_nx, ad_n_nx, bus_oe_nx;
    logic [7:0]      bus_out_nx;
    logic [2:0]      op_sel;
    logic [1:0]      cfg_sel;
    logic [8:0][7:0] snap_sel;
    xfer_t           xnx;

    assign w_in = {bus.w_chor, bus.w_cmin, bus.w_cseg,
                   bus.w_anio, bus.w_mes,  bus.w_dia,
                   bus.w_hor,  bus.w_min,  bus.w_seg};

    assign op_valid = (bus.op >= OP_CFG) && (bus.op <= OP_CHRONO);

    // Read data arrives on the last clock of DATA_A; target follows the F0 write
    assign capture = (state == S_DATA_A) && (cnt == '0) && (op_q == OP_READ) && (idx != 4'd0);
    assign rd_tgt  = idx - 4'd1;

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
        end
    end

    // Next-state: each phase counts down from T_PHASE-1, GAP advances the list
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        accept   = 1'b0;
        finish   = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                idx_nx = '0;
                if (bus.start && op_valid) begin
                    accept   = 1'b1;
                    state_nx = S_ADDR_A;
                    cnt_nx   = CNT_LOAD;
                end
            end
            default: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else begin
                    cnt_nx = CNT_LOAD;
                    case (state)
                        S_ADDR_A: state_nx = S_ADDR_B;
                        S_ADDR_B: state_nx = S_DATA_A;
                        S_DATA_A: state_nx = S_DATA_B;
                        S_DATA_B: state_nx = S_GAP;
                        S_GAP: begin
                            if (idx == last_idx(op_q)) begin
                                state_nx = S_IDLE;
                                cnt_nx   = '0;
                                idx_nx   = '0;
                                finish   = 1'b1;
                            end else begin
                                state_nx = S_ADDR_A;
                                idx_nx   = idx + 4'd1;
                            end
                        end
                        default: begin
                            state_nx = S_IDLE;
                            cnt_nx   = '0;
                            idx_nx   = '0;
                        end
                    endcase
                end
            end
        endcase
    end

    // Bus levels for the upcoming state, so strobes can leave a flop directly
    always_comb begin
        op_sel   = accept ? bus.op : op_q;
        cfg_sel  = accept ? {bus.cfg_format, bus.cfg_crono} : cfg_q;
        snap_sel = accept ? w_in : snap;
        xnx      = decode(op_sel, idx_nx, snap_sel, cfg_sel);

        cs_n_nx    = 1'b1;
        rd_n_nx    = 1'b1;
        wr_n_nx    = 1'b1;
        ad_n_nx    = 1'b1;
        bus_oe_nx  = 1'b0;
        bus_out_nx = 8'h00;
        case (state_nx)
            S_ADDR_A: begin
                cs_n_nx    = 1'b0;
                ad_n_nx    = 1'b0;
                wr_n_nx    = 1'b0;
                bus_oe_nx  = 1'b1;
                bus_out_nx = xnx.addr;
            end
            S_ADDR_B: begin
                cs_n_nx    = 1'b0;
                ad_n_nx    = 1'b0;
                bus_oe_nx  = 1'b1;
                bus_out_nx = xnx.addr;
            end
            S_DATA_A: begin
                cs_n_nx = 1'b0;
                if (xnx.rd) begin
                    rd_n_nx = 1'b0;
                end else begin
                    wr_n_nx    = 1'b0;
                    bus_oe_nx  = 1'b1;
                    bus_out_nx = xnx.data;
                end
            end
            S_DATA_B: begin
                cs_n_nx = 1'b0;
                if (!xnx.rd) begin
                    bus_oe_nx  = 1'b1;
                    bus_out_nx = xnx.data;
                end
            end
            default: ;
        endcase
    end

    // Command snapshot, read-back capture, status and strobe registers
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q      <= 3'd0;
            cfg_q     <= 2'b00;
            snap      <= '0;
            r_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            ad_n_q    <= 1'b1;
            bus_oe_q  <= 1'b0;
            bus_out_q <= 8'h00;
        end else begin
            if (accept) begin
                op_q  <= bus.op;
                cfg_q <= {bus.cfg_format, bus.cfg_crono};
                snap  <= w_in;
            end
            if (capture) begin
                r_q[rd_tgt] <= bus.bus_in;
            end
            busy_q    <= (state_nx != S_IDLE);
            done_q    <= finish;
            cs_n_q    <= cs_n_nx;
            rd_n_q    <= rd_n_nx;
            wr_n_q    <= wr_n_nx;
            ad_n_q    <= ad_n_nx;
            bus_oe_q  <= bus_oe_nx;
            bus_out_q <= bus_out_nx;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.cs_n    = cs_n_q;
    assign bus.rd_n    = rd_n_q;
    assign bus.wr_n    = wr_n_q;
    assign bus.ad_n    = ad_n_q;
    assign bus.bus_oe  = bus_oe_q;
    assign bus.bus_out = bus_out_q;

    assign bus.r_seg  = r_q[0];
    assign bus.r_min  = r_q[1];
    assign bus.r_hor  = r_q[2];
    assign bus.r_dia  = r_q[3];
    assign bus.r_mes  = r_q[4];
    assign bus.r_anio = r_q[5];
    assign bus.r_cseg = r_q[6];
    assign bus.r_cmin = r_q[7];
    assign bus.r_chor = r_q[8];

endmodule
`default_nettype wire
